// File: rtl/rv32_mvu_job_scheduler_if.sv
// MVU-side port of the job scheduler: the job snapshot and start strobe go out, and the done pulse comes back.
// Handshake: start is a 1-cycle strobe that launches one job; done is a 1-cycle pulse, honoured only while a job is running.
interface rv32_mvu_job_scheduler_if;
  logic [31:0] command;
  logic [31:0] wbase;
  logic [31:0] ibase;
  logic [31:0] obase;
  logic [31:0] prec;
  logic        start;
  logic        done;

  modport master (
    output command, wbase, ibase, obase, prec, start,
    input  done
  );

  modport slave (
    input  command, wbase, ibase, obase, prec, start,
    output done
  );
endinterface

// File: rtl/rv32_mvu_job_scheduler.sv
// Shares one MVU between barrel harts: latches per-hart start pulses as pending jobs, grants them round-robin,
// snapshots the winner's CSR slice, watches for completion or timeout and returns a per-hart irq pulse.
module rv32_mvu_job_scheduler #(
  parameter int NUM_HARTS   = 8,
  parameter int HART_W      = $clog2(NUM_HARTS),
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_HARTS-1:0]      mvu_start,
  input  logic [32*NUM_HARTS-1:0]   cfg_command,
  input  logic [32*NUM_HARTS-1:0]   cfg_wbase,
  input  logic [32*NUM_HARTS-1:0]   cfg_ibase,
  input  logic [32*NUM_HARTS-1:0]   cfg_obase,
  input  logic [32*NUM_HARTS-1:0]   cfg_prec,
  rv32_mvu_job_scheduler_if.master  mvu,
  output logic [HART_W-1:0]         grant_id,
  output logic                      busy,
  output logic [NUM_HARTS-1:0]      pending,
  output logic [NUM_HARTS-1:0]      mvu_irq,
  output logic                      timeout,
  output logic                      drop,
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

  state_t                state_q, state_n;
  logic [NUM_HARTS-1:0]  pending_q, pending_n;
  logic [HART_W-1:0]     rr_ptr_q, rr_ptr_n;
  logic [HART_W-1:0]     grant_q, grant_n;
  logic [31:0]           wdog_q, wdog_n;
  logic                  to_flag_q, to_flag_n;
  logic                  drop_q, drop_n;
  logic                  snap_load;
  logic [31:0]           cmd_q, wbase_q, ibase_q, obase_q, prec_q;

  logic [NUM_HARTS-1:0]  grant_mask, owner_mask, accept, clr;
  logic [HART_W-1:0]     pick;
  logic                  found;
  int                    idx;

  assign busy       = (state_q == ISSUE) || (state_q == BUSY);
  assign grant_mask = NUM_HARTS'(1) << grant_q;
  assign owner_mask = busy ? grant_mask : '0;

  // A start is dropped when the hart already has a job queued or currently owns the MVU.
  assign accept = mvu_start & ~pending_q & ~owner_mask;
  assign drop_n = |(mvu_start & ~accept);

  // Round-robin search starting at rr_ptr, wrapping explicitly so non-power-of-2 hart counts work.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_HARTS) idx = idx - NUM_HARTS;
      if (!found && pending_q[HART_W'(idx)]) begin
        found = 1'b1;
        pick  = HART_W'(idx);
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    rr_ptr_n  = rr_ptr_q;
    wdog_n    = wdog_q;
    to_flag_n = to_flag_q;
    snap_load = 1'b0;
    clr       = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_n   = pick;
          clr       = NUM_HARTS'(1) << pick;
          snap_load = 1'b1;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        wdog_n    = '0;
        to_flag_n = 1'b0;
        state_n   = BUSY;
      end
      BUSY: begin
        // done wins over a timeout landing in the same cycle
        if (mvu.done) begin
          state_n = DONE;
        end else begin
          if (wdog_q != '1) wdog_n = wdog_q + 32'd1;
          if ((TO_LIM != 32'd0) && (wdog_q >= TO_LIM - 32'd1)) begin
            state_n   = DONE;
            to_flag_n = 1'b1;
          end
        end
      end
      DONE: begin
        rr_ptr_n = (grant_q == HART_W'(NUM_HARTS - 1)) ? '0 : grant_q + HART_W'(1);
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    pending_n = (pending_q & ~clr) | accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      wdog_q    <= '0;
      to_flag_q <= 1'b0;
      drop_q    <= 1'b0;
      cmd_q     <= '0;
      wbase_q   <= '0;
      ibase_q   <= '0;
      obase_q   <= '0;
      prec_q    <= '0;
    end else begin
      state_q   <= state_n;
      pending_q <= pending_n;
      rr_ptr_q  <= rr_ptr_n;
      grant_q   <= grant_n;
      wdog_q    <= wdog_n;
      to_flag_q <= to_flag_n;
      drop_q    <= drop_n;
      if (snap_load) begin
        cmd_q   <= cfg_command[32*pick +: 32];
        wbase_q <= cfg_wbase[32*pick +: 32];
        ibase_q <= cfg_ibase[32*pick +: 32];
        obase_q <= cfg_obase[32*pick +: 32];
        prec_q  <= cfg_prec[32*pick +: 32];
      end
    end
  end

  assign mvu.command = cmd_q;
  assign mvu.wbase   = wbase_q;
  assign mvu.ibase   = ibase_q;
  assign mvu.obase   = obase_q;
  assign mvu.prec    = prec_q;
  assign mvu.start   = (state_q == ISSUE);

  assign grant_id  = grant_q;
  assign pending   = pending_q;
  assign mvu_irq   = (state_q == DONE) ? grant_mask : '0;
  assign timeout   = (state_q == DONE) && to_flag_q;
  assign drop      = drop_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_rv32_mvu_job_scheduler.sv
// Directed bench for the MVU job scheduler: round-robin order, fairness, drops, watchdog and async reset.
module tb_rv32_mvu_job_scheduler;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   mvu_start;
  logic [255:0] cfg_command, cfg_wbase, cfg_ibase, cfg_obase, cfg_prec;
  logic [2:0]   grant_id;
  logic         busy, timeout, drop;
  logic [7:0]   pending, mvu_irq;
  logic [1:0]   fsm_state;
  int           errors = 0;
  int           checks = 0;

  rv32_mvu_job_scheduler_if mvu ();

  rv32_mvu_job_scheduler #(.NUM_HARTS(8), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .mvu_start   (mvu_start),
    .cfg_command (cfg_command),
    .cfg_wbase   (cfg_wbase),
    .cfg_ibase   (cfg_ibase),
    .cfg_obase   (cfg_obase),
    .cfg_prec    (cfg_prec),
    .mvu         (mvu),
    .grant_id    (grant_id),
    .busy        (busy),
    .pending     (pending),
    .mvu_irq     (mvu_irq),
    .timeout     (timeout),
    .drop        (drop),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge with the FSM in IDLE and the hart's job pending; leaves in IDLE.
  task automatic serve(input int h, input logic [7:0] exp_pend, input logic [31:0] exp_wbase);
    logic [31:0] saved;
    @(negedge clk);
    check("issue_start", 32'(mvu.start), 32'd1);
    check("issue_grant", 32'(grant_id), h);
    check("issue_pend", 32'(pending), 32'(exp_pend));
    check("issue_wbase", mvu.wbase, exp_wbase);
    check("issue_cmd", mvu.command, 32'hC000_0000 + h);
    check("issue_prec", mvu.prec, 32'h0000_0100 + h);
    saved = cfg_wbase[h*32 +: 32];
    cfg_wbase[h*32 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("busy_start", 32'(mvu.start), 32'd0);
    check("busy_hold", mvu.wbase, exp_wbase);
    check("busy_busy", 32'(busy), 32'd1);
    mvu.done = 1'b1;
    @(negedge clk);
    mvu.done = 1'b0;
    check("done_irq", 32'(mvu_irq), 32'(8'(1 << h)));
    check("done_busy", 32'(busy), 32'd0);
    check("done_to", 32'(timeout), 32'd0);
    cfg_wbase[h*32 +: 32] = saved;
    @(negedge clk);
    check("idle_irq", 32'(mvu_irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed sim time %0t required end before it", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    mvu_start = '0;
    mvu.done = 1'b0;
    for (int h = 0; h < 8; h++) begin
      cfg_command[h*32 +: 32] = 32'hC000_0000 + h;
      cfg_wbase[h*32 +: 32]   = 32'h1000_0000 + h * 16;
      cfg_ibase[h*32 +: 32]   = 32'h2000_0000 + h * 16;
      cfg_obase[h*32 +: 32]   = 32'h3000_0000 + h * 16;
      cfg_prec[h*32 +: 32]    = 32'h0000_0100 + h;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mvu.start), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_irq", 32'(mvu_irq), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_wbase", mvu.wbase, 32'd0);
    rst = 1'b0;

    // Simultaneous requests from harts 0, 3, 5 with rr_ptr = 0
    @(negedge clk);
    mvu_start = 8'h29;
    @(negedge clk);
    mvu_start = '0;
    check("sim_pend", 32'(pending), 32'h29);
    check("sim_nostart", 32'(mvu.start), 32'd0);
    check("sim_drop", 32'(drop), 32'd0);
    serve(0, 8'h28, 32'h1000_0000);
    serve(3, 8'h20, 32'h1000_0030);
    serve(5, 8'h00, 32'h1000_0050);
    check("sim_drain", 32'(pending), 32'd0);

    // Single job on hart 2; mvu.start two edges after the request edge
    mvu_start = 8'h04;
    @(negedge clk);
    mvu_start = '0;
    check("one_pend", 32'(pending), 32'h04);
    check("one_nostart", 32'(mvu.start), 32'd0);
    serve(2, 8'h00, 32'h1000_0020);

    // Fairness: hart 1 re-requests in its own DONE while hart 4 waits (rr_ptr = 3)
    mvu_start = 8'h02;
    @(negedge clk);
    mvu_start = '0;
    check("fair_pend1", 32'(pending), 32'h02);
    @(negedge clk);
    check("fair_grant1", 32'(grant_id), 32'd1);
    check("fair_start1", 32'(mvu.start), 32'd1);
    mvu_start = 8'h10;
    @(negedge clk);
    mvu_start = '0;
    check("fair_pend4", 32'(pending), 32'h10);
    mvu.done = 1'b1;
    @(negedge clk);
    mvu.done = 1'b0;
    check("fair_irq1", 32'(mvu_irq), 32'h02);
    mvu_start = 8'h02;
    @(negedge clk);
    mvu_start = '0;
    check("fair_pend14", 32'(pending), 32'h12);
    check("fair_nodrop", 32'(drop), 32'd0);
    serve(4, 8'h02, 32'h1000_0040);
    serve(1, 8'h00, 32'h1000_0010);

    // Duplicate request for hart 6 and a request from the owner (hart 7) while BUSY
    mvu_start = 8'h80;
    @(negedge clk);
    mvu_start = '0;
    check("dup_pend7", 32'(pending), 32'h80);
    @(negedge clk);
    check("dup_grant7", 32'(grant_id), 32'd7);
    mvu_start = 8'h40;
    @(negedge clk);
    check("dup_pend6", 32'(pending), 32'h40);
    check("dup_drop0", 32'(drop), 32'd0);
    mvu_start = 8'h40;
    @(negedge clk);
    check("dup_drop6", 32'(drop), 32'd1);
    check("dup_pend6b", 32'(pending), 32'h40);
    mvu_start = 8'h80;
    @(negedge clk);
    mvu_start = '0;
    check("dup_drop7", 32'(drop), 32'd1);
    check("dup_pend6c", 32'(pending), 32'h40);
    check("dup_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("dup_drop_clr", 32'(drop), 32'd0);
    mvu.done = 1'b1;
    @(negedge clk);
    mvu.done = 1'b0;
    check("dup_irq7", 32'(mvu_irq), 32'h80);
    @(negedge clk);
    serve(6, 8'h00, 32'h1000_0060);
    check("dup_drain", 32'(pending), 32'd0);
    @(negedge clk);
    check("dup_noextra", 32'(mvu.start), 32'd0);
    check("dup_idle", 32'(busy), 32'd0);

    // Watchdog abort on hart 3 after 16 BUSY cycles; a late done is ignored
    mvu_start = 8'h08;
    @(negedge clk);
    mvu_start = '0;
    @(negedge clk);
    check("to_grant", 32'(grant_id), 32'd3);
    check("to_start", 32'(mvu.start), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("to_busy", 32'({busy, timeout, |mvu_irq}), 32'b100);
    end
    @(negedge clk);
    check("to_irq", 32'(mvu_irq), 32'h08);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_notbusy", 32'(busy), 32'd0);
    @(negedge clk);
    check("to_flag_clr", 32'(timeout), 32'd0);
    mvu.done = 1'b1;
    @(negedge clk);
    mvu.done = 1'b0;
    check("late_done", 32'({busy, mvu.start, timeout}), 32'd0);
    check("late_irq", 32'(mvu_irq), 32'd0);
    check("late_state", 32'(fsm_state), 32'd0);

    // done on the 16th BUSY cycle of hart 5 counts as normal completion
    mvu_start = 8'h20;
    @(negedge clk);
    mvu_start = '0;
    @(negedge clk);
    check("edge_grant", 32'(grant_id), 32'd5);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("edge_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("edge_busy16", 32'(busy), 32'd1);
    mvu.done = 1'b1;
    @(negedge clk);
    mvu.done = 1'b0;
    check("edge_irq", 32'(mvu_irq), 32'h20);
    check("edge_noto", 32'(timeout), 32'd0);
    @(negedge clk);

    // Async reset in the middle of hart 0's job
    mvu_start = 8'h01;
    @(negedge clk);
    mvu_start = '0;
    @(negedge clk);
    check("ar_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    check("ar_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_start", 32'(mvu.start), 32'd0);
    check("ar_irq", 32'(mvu_irq), 32'd0);
    check("ar_pend", 32'(pending), 32'd0);
    check("ar_wbase", mvu.wbase, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("ar_noirq", 32'(mvu_irq), 32'd0);
    mvu_start = 8'h02;
    @(negedge clk);
    mvu_start = '0;
    check("ar_irq_after", 32'(mvu_irq), 32'd0);
    check("ar_pend1", 32'(pending), 32'h02);
    serve(1, 8'h00, 32'h1000_0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
